// File: rtl/ir_key_dispatcher_pkg.sv
// Shared definitions for the IR key dispatcher: FSM encoding, counter width,
// default address/window constants and the queue entry layout.
package ir_pkg;

  localparam int         IR_CNT_W                = 8;
  localparam logic [7:0] IR_DEF_OWN_ADDRESS      = 8'h00;
  localparam int         IR_DEF_REPEAT_WINDOW_MS = 150;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILTER = 2'd1;
  localparam logic [1:0] ST_PUSH   = 2'd2;

  typedef struct packed {
    logic [7:0] code;
    logic       rpt;
  } key_entry_t;

  function automatic logic [IR_CNT_W-1:0] sat_inc(input logic [IR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ir_key_dispatcher_if.sv
// Key handshake between the dispatcher (master) and the key consumer (slave).
interface ir_key_dispatcher_if;
  import ir_pkg::*;

  logic [7:0] key_code;
  logic       key_repeat;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, key_repeat, key_valid, input key_ready);
  modport slave  (input key_code, key_repeat, key_valid, output key_ready);

endinterface

// File: rtl/ir_key_dispatcher_fifo.sv
// First-word-fall-through key queue; a write into a full queue is accepted
// when a read happens in the same cycle.
module ir_key_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_key_dispatcher.sv
// IR key dispatcher: filters decoded NEC frames by address, tags held keys
// as repeats, and queues them for a consumer with drop/filter/error stats.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | waiting for rx_data_ready; latches address/data
//   ST_FILTER | address check, repeat classification, hold reload
//   ST_PUSH   | write entry to queue or count a drop
module ir_key_dispatcher
  import ir_pkg::*;
#(
  parameter logic [7:0] OWN_ADDRESS      = IR_DEF_OWN_ADDRESS,
  parameter bit         PROMISCUOUS      = 1'b0,
  parameter int         FIFO_DEPTH       = 4,
  parameter int         TICKS_PER_MS     = 1000,
  parameter int         REPEAT_WINDOW_MS = IR_DEF_REPEAT_WINDOW_MS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_address,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  input  logic                  rx_error,
  ir_key_dispatcher_if.master   key_bus,
  output logic [IR_CNT_W-1:0]   dropped_count,
  output logic [IR_CNT_W-1:0]   filtered_count,
  output logic [IR_CNT_W-1:0]   error_count,
  input  logic                  clear_counts
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [1:0]    state;
  logic [7:0]    lat_addr;
  logic [7:0]    lat_data;
  logic [7:0]    last_code;
  logic [7:0]    hold_ms;
  logic          rpt_q;
  logic [PW-1:0] prescaler;
  logic          err_q;

  logic          addr_match;
  logic          match_hit;
  logic          ms_tick;
  logic          err_rise;
  logic          push_req;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  key_entry_t    wr_entry;
  key_entry_t    head;

  assign addr_match = PROMISCUOUS || (lat_addr == OWN_ADDRESS);
  assign match_hit  = (state == ST_FILTER) && addr_match;
  assign ms_tick    = (prescaler == PW'(TICKS_PER_MS - 1));
  assign err_rise   = rx_error && !err_q;
  assign push_req   = (state == ST_PUSH);
  assign pop        = key_bus.key_valid && key_bus.key_ready;
  assign wr_entry   = '{code: lat_data, rpt: rpt_q};

  // Capture FSM plus the per-frame registers it owns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_data  <= '0;
      last_code <= '0;
      rpt_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_data_ready) begin
            lat_addr <= rx_address;
            lat_data <= rx_data;
            state    <= ST_FILTER;
          end
        end
        ST_FILTER: begin
          if (addr_match) begin
            rpt_q     <= (hold_ms != 8'd0) && (lat_data == last_code);
            last_code <= lat_data;
            state     <= ST_PUSH;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running millisecond prescaler.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       prescaler <= '0;
    else if (ms_tick) prescaler <= '0;
    else              prescaler <= prescaler + 1'b1;
  end

  // Hold window: an error edge kills it, a matched frame reloads it,
  // otherwise it drains once per millisecond down to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_ms <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= rx_error;
      if (err_rise)                       hold_ms <= '0;
      else if (match_hit)                 hold_ms <= 8'(REPEAT_WINDOW_MS);
      else if (ms_tick && hold_ms != '0)  hold_ms <= hold_ms - 1'b1;
    end
  end

  // Saturating statistics; clear wins over any increment in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropped_count  <= '0;
      filtered_count <= '0;
      error_count    <= '0;
    end else if (clear_counts) begin
      dropped_count  <= '0;
      filtered_count <= '0;
      error_count    <= '0;
    end else begin
      if (push_req && fifo_full && !pop)            dropped_count  <= sat_inc(dropped_count);
      if ((state == ST_FILTER) && !addr_match)      filtered_count <= sat_inc(filtered_count);
      if (err_rise)                                 error_count    <= sat_inc(error_count);
    end
  end

  ir_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push_req),
    .wr_data (wr_entry),
    .rd_en   (key_bus.key_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Outputs are forced low while empty so stale RAM never shows after reset.
  assign key_bus.key_valid  = !fifo_empty;
  assign key_bus.key_code   = fifo_empty ? 8'h00 : head.code;
  assign key_bus.key_repeat = fifo_empty ? 1'b0  : head.rpt;

endmodule
